mult_corruption_monitor: RTL and testbench



---
 rtl/mult_corruption_monitor.sv | 174 +++++++++++++++++
 tb/tb_mult_corruption_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_corruption_monitor.sv
// Scores a locked 8x8 multiplier against a shift-add golden product and reports per-key error statistics.
// Define MCM_HD_ACCUM_EN to build the Hamming-distance popcount and accumulator.
module mult_corruption_monitor #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned KEY_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  input  logic [OP_W-1:0]      operand1_i,
  input  logic [OP_W-1:0]      operand2_i,
  input  logic [2*OP_W-1:0]    result_i,
  input  logic [KEY_W-1:0]     keyinput_i,
  input  logic                 epoch_clear_i,
  output logic                 done_o,
  output logic                 mismatch_o,
  output logic [2*OP_W-1:0]    golden_o,
  output logic                 rpt_valid_o,
  output logic [KEY_W-1:0]     rpt_key_o,
  output logic [CNT_W-1:0]     rpt_samples_o,
  output logic [CNT_W-1:0]     rpt_errors_o,
  output logic [CNT_W+4:0]     rpt_hd_o
);

  localparam int unsigned RES_W = 2 * OP_W;
  localparam int unsigned HD_W  = CNT_W + 5;
  localparam int unsigned IDX_W = (OP_W > 1) ? $clog2(OP_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [RES_W-1:0]    mcand_q;
  logic [OP_W-1:0]     mplier_q;
  logic [RES_W-1:0]    acc_q;
  logic [RES_W-1:0]    res_q;
  logic [IDX_W-1:0]    bit_cnt_q;
  logic [KEY_W-1:0]    key_q;
  logic                epoch_open_q;
  logic                clr_pend_q;
  logic [CNT_W-1:0]    smp_cnt_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic [RES_W-1:0]    diff;
  logic                key_chg;
  logic                clr_now;

  assign sample_ready_o = (state_q == IDLE);
  assign diff           = acc_q ^ res_q;
  assign key_chg        = epoch_open_q && (keyinput_i != key_q);
  assign clr_now        = clr_pend_q | epoch_clear_i;

`ifdef MCM_HD_ACCUM_EN
  logic [HD_W-1:0]     hd_cnt_q;
  logic [HD_W:0]       hd_sum;
  logic [5:0]          pop;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < RES_W; i++) begin
      pop = pop + {5'd0, diff[i]};
    end
    hd_sum = {1'b0, hd_cnt_q} + (HD_W+1)'(pop);
  end
`else
  assign rpt_hd_o = '0;
`endif

  // Multiplicand shifts left and multiplier right each step, equivalent to adding operand1 << i when operand2[i].
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      res_q         <= '0;
      bit_cnt_q     <= '0;
      key_q         <= '0;
      epoch_open_q  <= 1'b0;
      clr_pend_q    <= 1'b0;
      smp_cnt_q     <= '0;
      err_cnt_q     <= '0;
      done_o        <= 1'b0;
      mismatch_o    <= 1'b0;
      golden_o      <= '0;
      rpt_valid_o   <= 1'b0;
      rpt_key_o     <= '0;
      rpt_samples_o <= '0;
      rpt_errors_o  <= '0;
`ifdef MCM_HD_ACCUM_EN
      hd_cnt_q      <= '0;
      rpt_hd_o      <= '0;
`endif
    end else begin
      done_o      <= 1'b0;
      rpt_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_valid_i) begin
            mcand_q      <= {{OP_W{1'b0}}, operand1_i};
            mplier_q     <= operand2_i;
            acc_q        <= '0;
            res_q        <= result_i;
            bit_cnt_q    <= '0;
            key_q        <= keyinput_i;
            epoch_open_q <= 1'b1;
            state_q      <= MUL;
            if (epoch_clear_i) begin
              smp_cnt_q <= '0;
              err_cnt_q <= '0;
`ifdef MCM_HD_ACCUM_EN
              hd_cnt_q  <= '0;
`endif
            end else if (key_chg) begin
              rpt_valid_o   <= 1'b1;
              rpt_key_o     <= key_q;
              rpt_samples_o <= smp_cnt_q;
              rpt_errors_o  <= err_cnt_q;
              smp_cnt_q     <= '0;
              err_cnt_q     <= '0;
`ifdef MCM_HD_ACCUM_EN
              rpt_hd_o      <= hd_cnt_q;
              hd_cnt_q      <= '0;
`endif
            end
          end else if (epoch_clear_i) begin
            smp_cnt_q    <= '0;
            err_cnt_q    <= '0;
            epoch_open_q <= 1'b0;
`ifdef MCM_HD_ACCUM_EN
            hd_cnt_q     <= '0;
`endif
          end
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          bit_cnt_q <= bit_cnt_q + IDX_W'(1);
          if (bit_cnt_q == IDX_W'(OP_W - 1)) state_q <= CMP;
          if (epoch_clear_i) clr_pend_q <= 1'b1;
        end
        CMP: begin
          done_o     <= 1'b1;
          mismatch_o <= |diff;
          golden_o   <= acc_q;
          state_q    <= IDLE;
          clr_pend_q <= 1'b0;
          // A pending clear lands after this sample would have been counted, so the net effect is zero.
          if (clr_now) begin
            smp_cnt_q    <= '0;
            err_cnt_q    <= '0;
            epoch_open_q <= 1'b0;
`ifdef MCM_HD_ACCUM_EN
            hd_cnt_q     <= '0;
`endif
          end else begin
            if (smp_cnt_q != '1) smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            if ((|diff) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
`ifdef MCM_HD_ACCUM_EN
            hd_cnt_q <= hd_sum[HD_W] ? '1 : hd_sum[HD_W-1:0];
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_corruption_monitor.sv
// Directed, table-driven bench for mult_corruption_monitor; counters narrowed to reach saturation quickly.
// Expected rpt_hd_o follows MCM_HD_ACCUM_EN.
module tb_mult_corruption_monitor;

  localparam int OP_W  = 8;
  localparam int KEY_W = 32;
  localparam int CNT_W = 4;
  localparam logic [31:0] KA = 32'hF6301537;
  localparam logic [31:0] KB = 32'hF6301527;
  localparam logic [31:0] KC = 32'h12345678;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid;
  logic                ready;
  logic [OP_W-1:0]     op1, op2;
  logic [2*OP_W-1:0]   res;
  logic [KEY_W-1:0]    key;
  logic                clr;
  logic                done, mism;
  logic [2*OP_W-1:0]   golden;
  logic                rpt_valid;
  logic [KEY_W-1:0]    rpt_key;
  logic [CNT_W-1:0]    rpt_samples, rpt_errors;
  logic [CNT_W+4:0]    rpt_hd;

  int checks = 0;
  int errors = 0;

  mult_corruption_monitor #(.OP_W(OP_W), .KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sample_valid_i(valid), .sample_ready_o(ready),
    .operand1_i(op1), .operand2_i(op2), .result_i(res), .keyinput_i(key),
    .epoch_clear_i(clr), .done_o(done), .mismatch_o(mism), .golden_o(golden),
    .rpt_valid_o(rpt_valid), .rpt_key_o(rpt_key), .rpt_samples_o(rpt_samples),
    .rpt_errors_o(rpt_errors), .rpt_hd_o(rpt_hd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    logic [31:0] k;
    logic        c;
    logic [15:0] eg;
    logic        emm;
    logic        erv;
    logic [31:0] ek;
    int          es;
    int          ee;
    int          eh;
  } vec_t;

  vec_t tbl[10];

  function automatic int hx(input int h);
`ifdef MCM_HD_ACCUM_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({nm, " ready timeout"}, 64'(ready), 64'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
  endtask

  task automatic run_sample(input string nm, input vec_t v);
    int n;
    @(negedge clk);
    wait_ready(nm);
    valid = 1'b1; op1 = v.a; op2 = v.b; res = v.r; key = v.k; clr = v.c;
    @(posedge clk);
    #1;
    valid = 1'b0; clr = 1'b0;
    chk({nm, " rpt_valid"}, 64'(rpt_valid), 64'(v.erv));
    if (v.erv) begin
      chk({nm, " rpt_key"}, 64'(rpt_key), 64'(v.ek));
      chk({nm, " rpt_samples"}, 64'(rpt_samples), 64'(v.es));
      chk({nm, " rpt_errors"}, 64'(rpt_errors), 64'(v.ee));
      chk({nm, " rpt_hd"}, 64'(rpt_hd), 64'(hx(v.eh)));
    end
    chk({nm, " ready busy"}, 64'(ready), 64'd0);
    wait_done(n);
    chk({nm, " latency"}, 64'(n), 64'd9);
    chk({nm, " golden"}, 64'(golden), 64'(v.eg));
    chk({nm, " mismatch"}, 64'(mism), 64'(v.emm));
    chk({nm, " rpt pulse drop"}, 64'(rpt_valid), 64'd0);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r,
                              input logic [31:0] k, input logic c, input logic [15:0] eg,
                              input logic emm, input logic erv, input logic [31:0] ek,
                              input int es, input int ee, input int eh);
    vec_t v;
    v.a = a; v.b = b; v.r = r; v.k = k; v.c = c; v.eg = eg; v.emm = emm;
    v.erv = erv; v.ek = ek; v.es = es; v.ee = ee; v.eh = eh;
    return v;
  endfunction

  initial begin
    int n;
    logic seen;
    tbl[0] = mk(8'h29, 8'h7A, 16'h138A, KA, 1'b0, 16'h138A, 1'b0, 1'b0, 32'h0, 0, 0, 0);
    tbl[1] = mk(8'h11, 8'h11, 16'h0121, KA, 1'b0, 16'h0121, 1'b0, 1'b0, 32'h0, 0, 0, 0);
    tbl[2] = mk(8'h81, 8'h1C, 16'h0E1D, KA, 1'b0, 16'h0E1C, 1'b1, 1'b0, 32'h0, 0, 0, 0);
    tbl[3] = mk(8'h89, 8'hFF, 16'h8877, KB, 1'b0, 16'h8877, 1'b0, 1'b1, KA, 3, 1, 1);
    tbl[4] = mk(8'h81, 8'h1C, 16'hF1E3, KB, 1'b0, 16'h0E1C, 1'b1, 1'b0, 32'h0, 0, 0, 0);
    tbl[5] = mk(8'h29, 8'h7A, 16'h138A, KA, 1'b0, 16'h138A, 1'b0, 1'b1, KB, 2, 1, 16);
    tbl[6] = mk(8'h11, 8'h11, 16'h0121, KA, 1'b1, 16'h0121, 1'b0, 1'b0, 32'h0, 0, 0, 0);
    tbl[7] = mk(8'h89, 8'hFF, 16'h8877, KB, 1'b0, 16'h8877, 1'b0, 1'b1, KA, 1, 0, 0);
    tbl[8] = mk(8'h81, 8'h1C, 16'h0E1D, KA, 1'b1, 16'h0E1C, 1'b1, 1'b0, 32'h0, 0, 0, 0);
    tbl[9] = mk(8'h29, 8'h7A, 16'h138A, KB, 1'b0, 16'h138A, 1'b0, 1'b1, KA, 1, 1, 1);

    rst_n = 1'b0; valid = 1'b0; op1 = '0; op2 = '0; res = '0; key = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset mismatch", 64'(mism), 64'd0);
    chk("reset golden", 64'(golden), 64'd0);
    chk("reset rpt_valid", 64'(rpt_valid), 64'd0);
    chk("reset rpt_key", 64'(rpt_key), 64'd0);
    chk("reset rpt_samples", 64'(rpt_samples), 64'd0);
    chk("reset rpt_errors", 64'(rpt_errors), 64'd0);
    chk("reset rpt_hd", 64'(rpt_hd), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post reset pulses", 64'({done, rpt_valid, ready}), 64'b001);

    for (int i = 0; i < 10; i++) run_sample($sformatf("vec%0d", i), tbl[i]);

    // Clear raised mid-MUL takes effect after scoring: next accept must not report.
    @(negedge clk);
    wait_ready("pend");
    valid = 1'b1; op1 = 8'h11; op2 = 8'h11; res = 16'h0121; key = KB;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("pend rpt_valid", 64'(rpt_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    wait_done(n);
    chk("pend done seen", 64'(done), 64'd1);
    chk("pend golden", 64'(golden), 64'h0121);
    run_sample("pend next", mk(8'h29, 8'h7A, 16'h138A, KA, 1'b0, 16'h138A, 1'b0, 1'b0, 32'h0, 0, 0, 0));

    // Valid held high with operands changing during MUL.
    @(negedge clk);
    wait_ready("held");
    valid = 1'b1; op1 = 8'h29; op2 = 8'h7A; res = 16'h138A; key = KA;
    @(posedge clk);
    #1;
    chk("held rpt_valid", 64'(rpt_valid), 64'd0);
    @(negedge clk);
    op1 = 8'hFF; op2 = 8'hFF; res = 16'h0000;
    wait_done(n);
    chk("held latency", 64'(n), 64'd9);
    chk("held golden", 64'(golden), 64'h138A);
    chk("held mismatch", 64'(mism), 64'd0);
    chk("held ready gap", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    chk("held second accept", 64'(ready), 64'd0);
    chk("held done one cycle", 64'(done), 64'd0);
    valid = 1'b0;
    wait_done(n);
    chk("held2 latency", 64'(n), 64'd9);
    chk("held2 golden", 64'(golden), 64'hFE01);
    chk("held2 mismatch", 64'(mism), 64'd1);
    run_sample("held rpt", mk(8'h11, 8'h11, 16'h0121, KB, 1'b0, 16'h0121, 1'b0, 1'b1, KA, 3, 1, 8));

    // Reset four cycles after accept.
    @(negedge clk);
    wait_ready("rstmid");
    valid = 1'b1; op1 = 8'h89; op2 = 8'hFF; res = 16'h8877; key = KB;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("rstmid ready", 64'(ready), 64'd1);
    chk("rstmid rpt_key", 64'(rpt_key), 64'd0);
    chk("rstmid rpt_samples", 64'(rpt_samples), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("rstmid no done", 64'(seen), 64'd0);
    run_sample("rstmid new", mk(8'h29, 8'h7A, 16'h138A, KA, 1'b0, 16'h138A, 1'b0, 1'b0, 32'h0, 0, 0, 0));
    run_sample("rstmid rpt", mk(8'h11, 8'h11, 16'h0121, KB, 1'b0, 16'h0121, 1'b0, 1'b1, KA, 1, 0, 0));

    // Saturation: 33 corrupted samples under one key with 4-bit counters.
    run_sample("sat0", mk(8'h81, 8'h1C, 16'hF1E3, KC, 1'b0, 16'h0E1C, 1'b1, 1'b1, KB, 1, 0, 0));
    for (int i = 1; i < 33; i++)
      run_sample($sformatf("sat%0d", i), mk(8'h81, 8'h1C, 16'hF1E3, KC, 1'b0, 16'h0E1C, 1'b1, 1'b0, 32'h0, 0, 0, 0));
    run_sample("sat rpt", mk(8'h29, 8'h7A, 16'h138A, KA, 1'b0, 16'h138A, 1'b0, 1'b1, KC, 15, 15, 511));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
